// File: rtl/psum_collector.sv
// psum_collector
//   Collects the partial-sum stream leaving the last PE of a column,
//   accumulates nOUT sums per pass over nPASS passes in a local buffer, then
//   drains the finished sums over a valid/ready stream.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 begin a job (sampled only in IDLE)
//   cfg_npass, cfg_nout   passes per job / psums per pass, latched on start
//                         (0 is treated as 1, values above the limits clamp)
//   in_en, ipsum          psum stream from the PE (ipsum unsigned, 2*WIDTH+1)
//   o_valid, o_ready,     drain stream of accumulated sums
//   o_data
//   busy                  high while accumulating or draining
//   done                  one-cycle pulse after the last drain handshake
//   drop_err              sticky: a psum arrived outside ACCUM
//   sat_flag              sticky saturation indicator (PSUM_SAT_EN only)
//
// Build option
//   PSUM_SAT_EN  when defined, accumulation saturates at 2^ACC_WIDTH-1 and the
//                sat_flag port exists; otherwise sums wrap modulo 2^ACC_WIDTH.
module psum_collector #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int DEPTH     = 16,
  parameter int MAX_nPASS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_nPASS):0]    cfg_npass,
  input  logic [$clog2(DEPTH):0]        cfg_nout,
  input  logic                          in_en,
  input  logic [2*WIDTH:0]              ipsum,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [ACC_WIDTH-1:0]          o_data,
  output logic                          busy,
  output logic                          done,
`ifdef PSUM_SAT_EN
  output logic                          drop_err,
  output logic                          sat_flag
`else
  output logic                          drop_err
`endif
);

  localparam int A_WIDTH = 2*WIDTH + 1;
  localparam int PW      = $clog2(MAX_nPASS) + 1;
  localparam int NW      = $clog2(DEPTH) + 1;
  localparam int IW      = $clog2(DEPTH);
  localparam int AW1     = ACC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_buf [DEPTH];
  logic [NW-1:0]          r_nout, r_wr_ptr, r_rd_ptr;
  logic [PW-1:0]          r_npass, r_pass;
  logic                   r_valid, r_done, r_drop_err;
  logic [ACC_WIDTH-1:0]   r_data;
`ifdef PSUM_SAT_EN
  logic                   r_sat;
`endif

  logic                   w_acc_en, w_wr_wrap, w_last_pass, w_last_wr;
  logic                   w_hs, w_last_hs, w_sat_hit;
  logic [ACC_WIDTH-1:0]   w_acc_old, w_wr_data;
  logic [AW1-1:0]         w_sum;
  logic [NW-1:0]          w_rd_nxt;

  function automatic logic [NW-1:0] norm_nout(input logic [NW-1:0] n);
    if (n == '0)                return NW'(1);
    else if (n > NW'(DEPTH))    return NW'(DEPTH);
    else                        return n;
  endfunction

  function automatic logic [PW-1:0] norm_npass(input logic [PW-1:0] n);
    if (n == '0)                return PW'(1);
    else if (n > PW'(MAX_nPASS)) return PW'(MAX_nPASS);
    else                        return n;
  endfunction

  // One extra bit keeps the carry so overflow can be detected.
  function automatic logic [AW1-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                             input logic [A_WIDTH-1:0]   b);
    return {1'b0, a} + AW1'(b);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_wrap(input logic [AW1-1:0] s);
`ifdef PSUM_SAT_EN
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
    return s[ACC_WIDTH-1:0];
`endif
  endfunction

  assign w_acc_en    = (r_state == S_ACCUM) && in_en;
  assign w_wr_wrap   = (r_wr_ptr == r_nout - NW'(1));
  assign w_last_pass = (r_pass == r_npass - PW'(1));
  assign w_last_wr   = w_acc_en && w_wr_wrap && w_last_pass;
  assign w_hs        = r_valid && o_ready;
  assign w_last_hs   = w_hs && (r_rd_ptr == r_nout - NW'(1));
  assign w_rd_nxt    = r_rd_ptr + NW'(1);

  // The first pass overwrites stale buffer contents instead of adding to them.
  assign w_acc_old   = (r_pass == '0) ? '0 : r_buf[r_wr_ptr[IW-1:0]];
  assign w_sum       = acc_add(w_acc_old, ipsum);
  assign w_sat_hit   = w_sum[ACC_WIDTH];
  assign w_wr_data   = sat_wrap(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last_wr) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer storage carries no reset; its contents are rewritten by pass 0.
  always_ff @(posedge clk) begin
    if (w_acc_en) r_buf[r_wr_ptr[IW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nout     <= '0;
      r_npass    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_drop_err <= 1'b0;
      r_data     <= '0;
`ifdef PSUM_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (in_en && (r_state != S_ACCUM)) r_drop_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nout   <= norm_nout(cfg_nout);
            r_npass  <= norm_npass(cfg_npass);
            r_wr_ptr <= '0;
            r_pass   <= '0;
          end
        end
        S_ACCUM: begin
          if (in_en) begin
            if (w_wr_wrap) begin
              r_wr_ptr <= '0;
              r_pass   <= r_pass + PW'(1);
            end else begin
              r_wr_ptr <= r_wr_ptr + NW'(1);
            end
`ifdef PSUM_SAT_EN
            if (w_sat_hit) r_sat <= 1'b1;
`endif
          end
          if (w_last_wr) r_rd_ptr <= '0;
        end
        S_DRAIN: begin
          // r_rd_ptr always names the entry currently presented on o_data.
          if (!r_valid) begin
            r_data  <= r_buf[r_rd_ptr[IW-1:0]];
            r_valid <= 1'b1;
          end else if (w_last_hs) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_hs) begin
            r_rd_ptr <= w_rd_nxt;
            r_data   <= r_buf[w_rd_nxt[IW-1:0]];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign drop_err = r_drop_err;
`ifdef PSUM_SAT_EN
  assign sat_flag = r_sat;
`endif

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;
  localparam int WIDTH = 16;
  localparam int ACC_W = 33;
  localparam int DEPTH = 16;
  localparam int MAXNP = 8;
  localparam logic [32:0] ALL1 = {33{1'b1}};

  logic              clk = 1'b0;
  logic              rst, start, in_en, o_ready;
  logic [3:0]        cfg_npass;
  logic [4:0]        cfg_nout;
  logic [32:0]       ipsum;
  logic              o_valid, busy, done, drop_err;
  logic [ACC_W-1:0]  o_data;
`ifdef PSUM_SAT_EN
  logic              sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  psum_collector #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W), .DEPTH(DEPTH), .MAX_nPASS(MAXNP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_npass(cfg_npass), .cfg_nout(cfg_nout),
    .in_en(in_en), .ipsum(ipsum), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .busy(busy), .done(done),
`ifdef PSUM_SAT_EN
    .drop_err(drop_err), .sat_flag(sat_flag)
`else
    .drop_err(drop_err)
`endif
  );

  task automatic start_job(input int np, input int no);
    @(negedge clk);
    cfg_npass = 4'(np);
    cfg_nout  = 5'(no);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic feed(input logic [32:0] v);
    in_en = 1'b1;
    ipsum = v;
    @(negedge clk);
    in_en = 1'b0;
    ipsum = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_en = 1'b0; o_ready = 1'b1;
    ipsum = '0; cfg_npass = '0; cfg_nout = '0;
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_o_data got %0d want 0", o_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got %b want 0", drop_err); end
`ifdef PSUM_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // T1: one pass, four sums, drained back to back.
  task automatic test_single_pass;
    int cyc;
    o_ready = 1'b1;
    start_job(1, 4);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(ACC_W'(i));
      feed(33'(i));
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t1_latency_early o_valid got %b want 0", o_valid); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL t1_latency_first o_valid got %b want 1", o_valid); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      checks++;
      if (o_valid !== 1'b1) begin
        errors++; $display("FAIL t1_stream_gap cycle %0d o_valid got %b want 1", cyc, o_valid);
      end else begin
        checks++;
        if (o_data !== exp_q[0]) begin errors++; $display("FAIL t1_data got %0d want %0d", o_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t1_timeout remaining %0d want 0", exp_q.size()); end
    exp_q.delete();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done_pulse got %b want 1", done); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_after got %b want 0", o_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_width got %b want 0", done); end
  endtask

  // T2: three passes of two sums each.
  task automatic test_multi_pass;
    int cyc;
    o_ready = 1'b1;
    start_job(3, 2);
    exp_q.push_back(ACC_W'(30));
    exp_q.push_back(ACC_W'(60));
    for (int p = 0; p < 3; p++) begin
      feed(33'd10);
      feed(33'd20);
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (o_valid === 1'b1) begin
        checks++;
        if (o_data !== exp_q[0]) begin errors++; $display("FAIL t2_data got %0d want %0d", o_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t2_timeout remaining %0d want 0", exp_q.size()); end
    exp_q.delete();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done got %b want 1", done); end
    @(negedge clk);
  endtask

  // T3: T1 with o_ready toggling; each value must be held until accepted.
  task automatic test_backpressure;
    int cyc;
    o_ready = 1'b1;
    start_job(1, 4);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(ACC_W'(i));
      feed(33'(i));
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      o_ready = (cyc % 2 == 0);
      if (o_valid === 1'b1) begin
        checks++;
        if (o_data !== exp_q[0]) begin errors++; $display("FAIL t3_data got %0d want %0d", o_data, exp_q[0]); end
        if (o_ready) void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    o_ready = 1'b1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t3_timeout remaining %0d want 0", exp_q.size()); end
    exp_q.delete();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done got %b want 1", done); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t3_extra_output o_valid got %b want 0", o_valid); end
    @(negedge clk);
  endtask

  // T4: overflow at ACC_WIDTH = A_WIDTH = 33.
  task automatic test_overflow;
    int cyc;
    o_ready = 1'b1;
    start_job(2, 1);
`ifdef PSUM_SAT_EN
    exp_q.push_back(ALL1);
`else
    exp_q.push_back(ALL1 - 33'd1);
`endif
    feed(ALL1);
    feed(ALL1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (o_valid === 1'b1) begin
        checks++;
        if (o_data !== exp_q[0]) begin errors++; $display("FAIL t4_overflow got %0h want %0h", o_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t4_timeout remaining %0d want 0", exp_q.size()); end
    exp_q.delete();
`ifdef PSUM_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL t4_sat_flag got %b want 1", sat_flag); end
`endif
    @(negedge clk);
  endtask

  // T5: stray in_en in IDLE, and a start pulse while draining.
  task automatic test_drop_and_start;
    int cyc;
    in_en = 1'b1; ipsum = 33'd99;
    @(negedge clk);
    in_en = 1'b0; ipsum = '0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL t5_drop_err got %b want 1", drop_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_busy got %b want 0", busy); end
    o_ready = 1'b0;
    start_job(1, 2);
    exp_q.push_back(ACC_W'(5));
    exp_q.push_back(ACC_W'(6));
    feed(33'd5);
    feed(33'd6);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_drain got %b want 1", busy); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL t5_valid_held got %b want 1", o_valid); end
    o_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (o_valid === 1'b1) begin
        checks++;
        if (o_data !== exp_q[0]) begin errors++; $display("FAIL t5_data got %0d want %0d", o_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t5_timeout remaining %0d want 0", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_start_ignored busy got %b want 0", busy); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL t5_drop_sticky got %b want 1", drop_err); end
  endtask

  // T6: reset mid-ACCUM, then a fresh T1 job.
  task automatic test_reset_mid_job;
    o_ready = 1'b1;
    start_job(2, 4);
    feed(33'd7);
    feed(33'd8);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b want 0", busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL t6_o_valid got %b want 0", o_valid); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL t6_drop_err got %b want 0", drop_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_single_pass();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_overflow();
    test_drop_and_start();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
